// File: rtl/usb3_descramble_if.sv
// usb3_descramble_if -- symbol-stream bundle for the USB3 receive descrambler.
//
// Signals
//   enable        1 = descramble D symbols, 0 = bypass with the LFSR parked at its seed
//   raw_data      received symbols, lane 3 [31:24] first in time, lane 0 [7:0] last
//   raw_datak     per-lane K flag (bit i belongs to lane i)
//   raw_valid     raw_data/raw_datak qualify this cycle
//   proc_data     descrambled, SKP-stripped word in the same lane order
//   proc_datak    K flags aligned to proc_data
//   proc_valid    proc_data/proc_datak qualify this cycle
//   skp_strip     SKP halfwords removed from the word accepted two cycles earlier
//   err_skp_align pulse for a SKP that is not part of an aligned SKP halfword
//
// Modports
//   master  the upstream side: drives enable/raw_*, observes the processed stream
//   slave   the descrambler: consumes enable/raw_*, drives proc_*/status
interface usb3_descramble_if;
  logic        enable;
  logic [31:0] raw_data;
  logic [3:0]  raw_datak;
  logic        raw_valid;
  logic [31:0] proc_data;
  logic [3:0]  proc_datak;
  logic        proc_valid;
  logic [1:0]  skp_strip;
  logic        err_skp_align;

  modport master (
    output enable, raw_data, raw_datak, raw_valid,
    input  proc_data, proc_datak, proc_valid, skp_strip, err_skp_align
  );

  modport slave (
    input  enable, raw_data, raw_datak, raw_valid,
    output proc_data, proc_datak, proc_valid, skp_strip, err_skp_align
  );
endinterface

// File: rtl/usb3_descramble.sv
// usb3_descramble -- USB3 receive-side descrambler with SKP halfword stripping.
//
// Two register stages:
//   stage A  descrambles all four lanes of a word in one cycle (lane 3 first in
//            time) and flags which halfwords survive SKP stripping.
//   stage B  packs surviving halfwords, holding at most one leftover halfword,
//            and emits a full word whenever two halfwords are available.
//
// LFSR: x^16+x^5+x^4+x^3+1, seed 16'hFFFF, Galois form shifting left. The
// keystream byte for a symbol is the MSB taken before each of the 8 steps,
// first step in bit 0. D symbols are XORed with it, then the LFSR advances.
// COM reloads the seed for the following lanes; SKP neither XORs nor advances;
// any other K symbol passes unchanged and advances.
//
// Ports
//   local_clk  sole clock, rising edge
//   reset      asynchronous, active-high
//   bus        usb3_descramble_if.slave (enable, raw_*, proc_*, skp_strip,
//              err_skp_align)
//
// Build option
//   USB3_DESCRAMBLE_SKP_STRIP_EN  when defined, halfwords made of two SKP
//   symbols are removed from the stream. When undefined, SKPs pass through,
//   every valid word appears two cycles later and skp_strip stays 0.
module usb3_descramble (
  input logic              local_clk,
  input logic              reset,
  usb3_descramble_if.slave bus
);

  localparam logic [15:0] SEED      = 16'hFFFF;
  localparam logic [15:0] POLY_TAPS = 16'h0039;
  localparam logic [7:0]  COM_SYM   = 8'hBC;
  localparam logic [7:0]  SKP_SYM   = 8'h3C;

  // Advance the LFSR by one symbol (8 steps).
  function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int unsigned n = 0; n < 8; n++) begin
      t = {t[14:0], 1'b0} ^ (t[15] ? POLY_TAPS : 16'h0000);
    end
    return t;
  endfunction

  // Keystream byte for the current LFSR state; first step lands in bit 0.
  function automatic logic [7:0] lfsr_byte(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  b;
    t = s;
    b = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      b = {t[15], b[7:1]};
      t = {t[14:0], 1'b0} ^ (t[15] ? POLY_TAPS : 16'h0000);
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage A: descramble
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] cur_lfsr;
  logic [31:0] desc_d;
  logic [3:0]  skp_lane;
  logic [1:0]  lane;
  logic [7:0]  sym;
  logic        sym_k;
  logic        keep_hi_d;
  logic        keep_lo_d;
  logic        err_d;
  logic [1:0]  strip_d;

  logic        a_valid;
  logic [31:0] a_data;
  logic [3:0]  a_datak;
  logic        a_keep_hi;
  logic        a_keep_lo;
  logic        a_err;
  logic [1:0]  a_strip;

  // Lanes are walked in time order so a COM reseeds the lanes after it.
  always_comb begin
    cur_lfsr = lfsr_q;
    desc_d   = bus.raw_data;
    skp_lane = '0;
    lane     = '0;
    sym      = '0;
    sym_k    = 1'b0;
    lfsr_d   = lfsr_q;
    for (int unsigned n = 0; n < 4; n++) begin
      lane  = 2'(32'd3 - n);
      sym   = bus.raw_data[{lane, 3'b000} +: 8];
      sym_k = bus.raw_datak[lane];
      if (sym_k && sym == SKP_SYM) begin
        skp_lane[lane] = 1'b1;
      end else if (sym_k && sym == COM_SYM) begin
        cur_lfsr = SEED;
      end else begin
        if (!sym_k) begin
          desc_d[{lane, 3'b000} +: 8] = sym ^ lfsr_byte(cur_lfsr);
        end
        cur_lfsr = lfsr_step8(cur_lfsr);
      end
    end
    if (!bus.enable) begin
      desc_d = bus.raw_data;
      lfsr_d = SEED;
    end else if (bus.raw_valid) begin
      lfsr_d = cur_lfsr;
    end
  end

`ifdef USB3_DESCRAMBLE_SKP_STRIP_EN
  assign keep_hi_d = ~(skp_lane[3] & skp_lane[2]);
  assign keep_lo_d = ~(skp_lane[1] & skp_lane[0]);
`else
  assign keep_hi_d = 1'b1;
  assign keep_lo_d = 1'b1;
`endif

  // A lone SKP inside a halfword is misaligned regardless of stripping.
  assign err_d   = (skp_lane[3] ^ skp_lane[2]) | (skp_lane[1] ^ skp_lane[0]);
  assign strip_d = {1'b0, ~keep_hi_d} + {1'b0, ~keep_lo_d};

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      lfsr_q    <= SEED;
      a_valid   <= 1'b0;
      a_data    <= '0;
      a_datak   <= '0;
      a_keep_hi <= 1'b0;
      a_keep_lo <= 1'b0;
      a_err     <= 1'b0;
      a_strip   <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      a_valid   <= bus.raw_valid;
      a_data    <= desc_d;
      a_datak   <= bus.raw_datak;
      a_keep_hi <= keep_hi_d;
      a_keep_lo <= keep_lo_d;
      a_err     <= err_d;
      a_strip   <= strip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: halfword packer
  // ---------------------------------------------------------------------------
  // Halfwords carry {datak[1:0], data[15:0]}.
  logic        held_q;
  logic [17:0] held_hw;
  logic [17:0] hw_hi;
  logic [17:0] hw_lo;
  logic        take_hi;
  logic        take_lo;
  logic [1:0]  n_avail;
  logic [17:0] hw0;
  logic [17:0] hw1;
  logic [17:0] hw2;

  logic [31:0] proc_data_q;
  logic [3:0]  proc_datak_q;
  logic        proc_valid_q;
  logic [1:0]  skp_strip_q;
  logic        err_q;

  assign hw_hi   = {a_datak[3:2], a_data[31:16]};
  assign hw_lo   = {a_datak[1:0], a_data[15:0]};
  assign take_hi = a_valid & a_keep_hi;
  assign take_lo = a_valid & a_keep_lo;

  // Candidates in stream order: leftover, then upper, then lower halfword.
  // hw1 is only consumed with two or more available, hw2 only with three,
  // which lets each slot be chosen from a couple of flags instead of a shifter.
  always_comb begin
    n_avail = {1'b0, held_q} + {1'b0, take_hi} + {1'b0, take_lo};
    hw0     = held_q ? held_hw : (take_hi ? hw_hi : hw_lo);
    hw1     = (held_q && take_hi) ? hw_hi : hw_lo;
    hw2     = hw_lo;
  end

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      held_q       <= 1'b0;
      held_hw      <= '0;
      proc_data_q  <= '0;
      proc_datak_q <= '0;
      proc_valid_q <= 1'b0;
      skp_strip_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      if (n_avail >= 2'd2) begin
        proc_valid_q <= 1'b1;
        proc_data_q  <= {hw0[15:0], hw1[15:0]};
        proc_datak_q <= {hw0[17:16], hw1[17:16]};
        held_q       <= (n_avail == 2'd3);
        held_hw      <= hw2;
      end else begin
        proc_valid_q <= 1'b0;
        proc_data_q  <= '0;
        proc_datak_q <= '0;
        held_q       <= (n_avail == 2'd1);
        held_hw      <= hw0;
      end
      skp_strip_q <= a_valid ? a_strip : 2'd0;
      err_q       <= a_valid & a_err;
    end
  end

  assign bus.proc_data     = proc_data_q;
  assign bus.proc_datak    = proc_datak_q;
  assign bus.proc_valid    = proc_valid_q;
  assign bus.skp_strip     = skp_strip_q;
  assign bus.err_skp_align = err_q;

endmodule

// File: tb/tb_usb3_descramble.sv
// tb_usb3_descramble -- randomized self-checking bench for usb3_descramble.
// The reference keeps a precomputed keystream indexed by symbols-since-seed
// and a queue of surviving halfwords; words are popped two halfwords at a time.
module tb_usb3_descramble;

  logic local_clk = 1'b0;
  logic reset;

  usb3_descramble_if bus ();

  usb3_descramble dut (
    .local_clk (local_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 local_clk = ~local_clk;

`ifdef USB3_DESCRAMBLE_SKP_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    logic [1:0]  strip;
    logic        err;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  ks [16384];
  int unsigned ks_pos;
  logic [17:0] hq [$];
  exp_t        pending;
  logic [31:0] cap [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Keystream byte n = LFSR MSB before steps 8n..8n+7, starting from the seed.
  task automatic build_keystream();
    logic [15:0] s;
    logic [7:0]  b;
    s = 16'hFFFF;
    for (int n = 0; n < 16384; n++) begin
      b = '0;
      for (int i = 0; i < 8; i++) begin
        b = {s[15], b[7:1]};
        s = s[15] ? ((s << 1) ^ 16'h0039) : (s << 1);
      end
      ks[n] = b;
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t r;
    r.v = 1'b0; r.d = '0; r.k = '0; r.strip = '0; r.err = 1'b0;
    return r;
  endfunction

  task automatic model_step(input bit en, input logic [31:0] d, input logic [3:0] k,
                            input bit v, output exp_t r);
    logic [31:0] outw;
    logic [3:0]  skp;
    logic [7:0]  b;
    bit          kk;
    logic [17:0] a;
    logic [17:0] c;
    r = zero_exp();
    if (v) begin
      outw = '0;
      skp  = '0;
      for (int i = 3; i >= 0; i--) begin
        b  = 8'(d >> (8 * i));
        kk = ((k >> i) & 4'd1) != 4'd0;
        if (kk && b == 8'h3C) skp = skp | (4'd1 << i);
        else if (en) begin
          if (kk && b == 8'hBC) ks_pos = 0;
          else begin
            if (!kk) b = b ^ ks[ks_pos];
            ks_pos++;
          end
        end
        outw = {outw[23:0], b};
      end
      if (skp[3] != skp[2] || skp[1] != skp[0]) r.err = 1'b1;
      if (STRIP && skp[3:2] == 2'b11) r.strip = r.strip + 2'd1;
      else hq.push_back({k[3:2], outw[31:16]});
      if (STRIP && skp[1:0] == 2'b11) r.strip = r.strip + 2'd1;
      else hq.push_back({k[1:0], outw[15:0]});
      if (hq.size() >= 2) begin
        a = hq.pop_front();
        c = hq.pop_front();
        r.v = 1'b1;
        r.d = {a[15:0], c[15:0]};
        r.k = {a[17:16], c[17:16]};
      end
    end
    if (!en) ks_pos = 0;
  endtask

  // Apply one input word for one clock; check the output registered at that edge.
  task automatic cycle(input bit en, input logic [31:0] d, input logic [3:0] k, input bit v);
    exp_t r;
    bus.enable    = en;
    bus.raw_data  = d;
    bus.raw_datak = k;
    bus.raw_valid = v;
    model_step(en, d, k, v, r);
    @(posedge local_clk);
    #1;
    check("proc_valid", 32'(bus.proc_valid), 32'(pending.v));
    if (pending.v) begin
      check("proc_data", bus.proc_data, pending.d);
      check("proc_datak", 32'(bus.proc_datak), 32'(pending.k));
    end
    check("skp_strip", 32'(bus.skp_strip), 32'(pending.strip));
    check("err_skp_align", 32'(bus.err_skp_align), 32'(pending.err));
    if (bus.proc_valid) cap.push_back(bus.proc_data);
    pending = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_proc_valid", 32'(bus.proc_valid), 32'd0);
    check("rst_proc_data", bus.proc_data, 32'd0);
    check("rst_proc_datak", 32'(bus.proc_datak), 32'd0);
    check("rst_skp_strip", 32'(bus.skp_strip), 32'd0);
    check("rst_err", 32'(bus.err_skp_align), 32'd0);
    @(posedge local_clk);
    #1;
    check("rst_edge_valid", 32'(bus.proc_valid), 32'd0);
    check("rst_edge_data", bus.proc_data, 32'd0);
    reset = 1'b0;
    hq.delete();
    ks_pos  = 0;
    pending = zero_exp();
  endtask

  task automatic loopback();
    logic [8:0]  plain [$];
    logic [8:0]  scr   [$];
    logic [8:0]  s;
    logic [31:0] expw  [$];
    logic [31:0] dbe;
    logic [31:0] w;
    logic [3:0]  wk;
    logic [7:0]  b;
    int unsigned pos;
    int unsigned cnt;
    dbe = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) plain.push_back({1'b1, 8'hBC});
    for (int j = 0; j < 32; j++) begin
      if (j == 2 || j == 12 || j == 14 || j == 30) begin
        plain.push_back({1'b1, 8'h3C});
        plain.push_back({1'b1, 8'h3C});
      end
      plain.push_back({1'b0, 8'(dbe >> (8 * (3 - (j % 4))))});
    end
    // Transmit-side scrambler built from the same keystream
    pos = 0;
    foreach (plain[i]) begin
      s = plain[i];
      b = s[7:0];
      if (s[8] && b == 8'h3C) begin
      end else if (s[8] && b == 8'hBC) pos = 0;
      else begin
        if (!s[8]) b = b ^ ks[pos];
        pos++;
      end
      scr.push_back({s[8], b});
    end
    // Expected receive stream: the plain symbols, SKP pairs removed if stripping
    w = '0; cnt = 0;
    for (int i = 0; i < plain.size(); i += 2) begin
      if (STRIP && plain[i] == {1'b1, 8'h3C} && plain[i+1] == {1'b1, 8'h3C}) continue;
      w = {w[15:0], plain[i][7:0], plain[i+1][7:0]};
      cnt += 2;
      if (cnt == 4) begin
        expw.push_back(w);
        cnt = 0;
      end
    end
    cap.delete();
    for (int i = 0; i < scr.size(); i += 4) begin
      w  = {scr[i][7:0], scr[i+1][7:0], scr[i+2][7:0], scr[i+3][7:0]};
      wk = {scr[i][8], scr[i+1][8], scr[i+2][8], scr[i+3][8]};
      cycle(1'b1, w, wk, 1'b1);
    end
    idle(3);
    check("lb_count", cap.size(), expw.size());
    for (int i = 0; i < cap.size() && i < expw.size(); i++) check("lb_word", cap[i], expw[i]);
  endtask

  function automatic logic [8:0] rand_sym();
    int unsigned p;
    p = $urandom_range(99);
    if (p < 70) return {1'b0, 8'($urandom)};
    if (p < 80) return {1'b1, 8'h3C};
    if (p < 85) return {1'b1, 8'hBC};
    if (p < 92) return {1'b1, 8'hFC};
    return {1'b1, 8'h1C};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  sy [4];
    logic [31:0] w;
    logic [3:0]  wk;
    bit          en;

    bus.enable    = 1'b0;
    bus.raw_data  = '0;
    bus.raw_datak = '0;
    bus.raw_valid = 1'b0;
    build_keystream();
    do_reset();

    // Plain bypass word
    cycle(1'b0, 32'h1234_5678, 4'h0, 1'b1);
    idle(2);

    // Upper SKP halfword removed, leftover halfword carried across words
    cycle(1'b0, 32'h3C3C_1111, 4'b1100, 1'b1);
    cycle(1'b0, 32'h2222_3333, 4'b0000, 1'b1);
    cycle(1'b0, 32'h4444_5555, 4'b0000, 1'b1);
    cycle(1'b0, 32'h0, 4'h0, 1'b0);

    // Reset while a halfword may be held, then a fresh word
    do_reset();
    cycle(1'b0, 32'h1234_5678, 4'h0, 1'b1);
    idle(2);

    // Full SKP word between two data words
    cycle(1'b0, 32'hAAAA_BBBB, 4'h0, 1'b1);
    cycle(1'b0, 32'h3C3C_3C3C, 4'hF, 1'b1);
    cycle(1'b0, 32'hCCCC_DDDD, 4'h0, 1'b1);
    idle(2);

    // Misaligned SKP, bypassed and descrambled after a COM reseed
    cycle(1'b0, 32'h113C_2222, 4'b0100, 1'b1);
    cycle(1'b1, 32'hBCBC_BCBC, 4'hF, 1'b1);
    cycle(1'b1, 32'h113C_2222, 4'b0100, 1'b1);
    cycle(1'b1, 32'h0102_0304, 4'h0, 1'b1);
    idle(3);

    // Scrambler loopback with SKP insertion
    do_reset();
    loopback();

    // Random traffic
    en = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(19) == 0) en = ~en;
      for (int i = 0; i < 4; i++) sy[i] = rand_sym();
      if ($urandom_range(9) == 0) begin sy[0] = {1'b1, 8'h3C}; sy[1] = {1'b1, 8'h3C}; end
      if ($urandom_range(9) == 0) begin sy[2] = {1'b1, 8'h3C}; sy[3] = {1'b1, 8'h3C}; end
      w  = {sy[0][7:0], sy[1][7:0], sy[2][7:0], sy[3][7:0]};
      wk = {sy[0][8], sy[1][8], sy[2][8], sy[3][8]};
      cycle(en, w, wk, $urandom_range(3) != 0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb3_descramble.md
USB3_DESCRAMBLE -- requirements
Module: usb3_descramble

Interface
REQ-001 SHALL: local_clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: enable  input  1  1 = descramble data symbols; 0 = bypass descrambling, LFSR held at seed.
REQ-004 SHALL: raw_data  input  32  received symbols; lane 3 [31:24] first in time, lane 0 [7:0] last.
REQ-005 SHALL: raw_datak  input  4  per-lane K flag (bit i for lane i).
REQ-006 SHALL: raw_valid  input  1  raw_data/raw_datak qualify this cycle.
REQ-007 SHALL: proc_data  output  32  descrambled, SKP-stripped word; same lane order as raw_data.
REQ-008 SHALL: proc_datak  output  4  K flags aligned to proc_data.
REQ-009 SHALL: proc_valid  output  1  proc_data/proc_datak qualify this cycle.
REQ-010 SHALL: skp_strip  output  2  number of SKP halfwords removed from the word accepted two cycles earlier (0..2).
REQ-011 SHALL: err_skp_align  output  1  one-cycle pulse on a SKP not forming an aligned halfword pair.

Function
REQ-012 SHALL: LFSR 16 bits, polynomial x^16+x^5+x^4+x^3+1, seed 16'hFFFF, advanced 8 steps per symbol, lanes in time order 3,2,1,0, all four lane steps computed within one cycle.
REQ-013 SHALL: D symbol (datak=0) is XORed with the current LFSR byte, then the LFSR advances.
REQ-014 SHALL: K symbol is passed unchanged and advances the LFSR, except for COM and SKP.
REQ-015 SHALL: COM (K28.5, 8'hBC, datak=1) passes unchanged and reloads the seed; later lanes of the same word use the seed.
REQ-016 SHALL: SKP (K28.1, 8'h3C, datak=1) is never XORed and never advances the LFSR.
REQ-017 SHALL: Stage A registers the descrambled word and per-halfword keep flags one cycle after raw_valid; raw_valid=0 leaves the LFSR unchanged.
REQ-018 SHALL: A halfword whose lanes are both SKP is dropped; the first-in-time halfword is [31:16].
REQ-019 SHALL: A lone SKP in a halfword is kept as data and pulses err_skp_align in the stage-B cycle.
REQ-020 SHALL: Stage B holds 0 or 1 leftover halfword plus 0..2 kept halfwords from stage A; with at least 2 available it emits {oldest, next} with proc_valid=1, otherwise proc_valid=0.
REQ-021 SHALL: Stage B never exceeds 3 halfwords, so no overflow and no backpressure exist.
REQ-022 SHALL: Latency with no held halfword is 2 cycles from raw input to proc output; a held halfword delays data by up to one word slot.
REQ-023 SHALL: A COM never waits behind a held halfword; the leftover remains in the stream in order.
REQ-024 SHALL: enable does not gate SKP stripping.
REQ-025 SHALL: A 1-to-0 transition of enable reloads the seed on the next edge.

Reset
REQ-026 SHALL: While reset=1: proc_data=0, proc_datak=0, proc_valid=0, skp_strip=0, err_skp_align=0, LFSR=16'hFFFF, held-halfword count=0, stage A cleared.
REQ-027 SHALL: Reset asserted mid-stream discards the held halfword and all in-flight words; the first word after release is treated as fresh.

Configuration
REQ-028 SHALL: With macro USB3_DESCRAMBLE_SKP_STRIP_EN defined, SKP halfwords are removed per REQ-018 to REQ-023.
REQ-029 SHALL: Without the macro, SKP symbols pass through (still not XORed, still not advancing the LFSR); every valid input yields proc_valid exactly 2 cycles later; skp_strip stays 0; err_skp_align remains functional.

Verification
REQ-030 SHALL: Reset mid-stream with a held halfword: next edge proc_valid=0, proc_data=0; after release, input 0x1234_5678 (enable=0) gives proc 0x1234_5678 two cycles later.
REQ-031 SHALL: enable=0, inputs 0x3C3C1111/k=1100, 0x22223333/k=0, 0x44445555/k=0 give proc 0x11112222, then 0x33334444, with 0x5555 held and skp_strip=1 for the first word.
REQ-032 SHALL: enable=0, input 0x3C3C3C3C/k=1111 between two data words gives one proc_valid=0 cycle, skp_strip=2, and both data words unchanged.
REQ-033 SHALL: Loopback from usb3_scramble: COM word then 0xDEADBEEF x8 with SKP insertion active gives proc 0xDEADBEEF x8 in order, with no SKP visible.
REQ-034 SHALL: Input 0x113C2222/k=0100 gives err_skp_align=1 for one cycle, with the word passed through and the LFSR not advanced for lane 2.
REQ-035 SHALL: With USB3_DESCRAMBLE_SKP_STRIP_EN undefined, input 0x3C3C3C3C/k=1111 gives proc 0x3C3C3C3C, proc_valid=1 at 2 cycles, and skp_strip=0.
